// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache data array: SRAM geometry,
// FSM state encoding and offset-to-bank decode.
package icache_pkg;

  localparam int unsigned SRAM_W = 128;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRefill
  } state_e;

  // Each 128-bit macro row holds 16 bytes of the line.
  function automatic int unsigned bank_of(input int unsigned offset);
    return offset / 16;
  endfunction

endpackage

// File: rtl/icache_refill_ctr.sv
// Refill beat counter: tracks which beat of the line is next and decodes it
// into the target bank and the lane inside that bank's 128-bit row.
module icache_refill_ctr #(
  parameter int unsigned BEATS = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned LaneW = $clog2(LANES),
  parameter int unsigned BankW = $clog2(BEATS) - LaneW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BankW-1:0] bank_o,
  output logic [LaneW-1:0] lane_o,
  output logic             last_o
);

  localparam int unsigned CntW = BankW + LaneW;

  logic [CntW-1:0] cnt_q;

  // Count accepted beats; wrap after the last beat so the next line starts at 0.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

  assign bank_o = cnt_q[CntW-1:LaneW];
  assign lane_o = cnt_q[LaneW-1:0];
  assign last_o = (cnt_q == CntW'(BEATS - 1));

endmodule

// File: rtl/icache_data_array.sv
// Instruction-cache data store front-end for WAYS x BANKS single-port SRAM
// macros. Serves 1-cycle fetch reads and writes refill beat streams.
// Optional ICACHE_DATA_FWD_EN: reads hitting the line under refill are served
// from a line buffer once their word has arrived.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int unsigned IDX_LEN = 7,
  parameter int unsigned BLK_LEN = 6,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned BEAT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rd_valid_i,
  output logic                             rd_ready_o,
  input  logic [IDX_LEN-1:0]               rd_index_i,
  input  logic [BLK_LEN-1:0]               rd_offset_i,
  input  logic [WAYS-1:0]                  rd_way_i,
  output logic                             rsp_valid_o,
  output logic [WORD_W-1:0]                rsp_data_o,
  input  logic                             rf_start_i,
  input  logic [IDX_LEN-1:0]               rf_index_i,
  input  logic [WAYS-1:0]                  rf_way_i,
  input  logic                             rf_beat_valid_i,
  input  logic [BEAT_W-1:0]                rf_beat_data_i,
  output logic                             rf_beat_ready_o,
  output logic                             rf_done_o,
  output logic [WAYS*(2**BLK_LEN/16)*IDX_LEN-1:0] sram_addr_o,
  output logic [WAYS*(2**BLK_LEN/16)-1:0]         sram_cen_o,
  output logic [WAYS*(2**BLK_LEN/16)-1:0]         sram_wen_o,
  output logic [WAYS*(2**BLK_LEN/16)*SRAM_W-1:0]  sram_wmask_o,
  output logic [WAYS*(2**BLK_LEN/16)*SRAM_W-1:0]  sram_wdata_o,
  input  logic [WAYS*(2**BLK_LEN/16)*SRAM_W-1:0]  sram_rdata_i
);

  localparam int unsigned BANKS  = (2**BLK_LEN) / 16;
  localparam int unsigned BEATS  = (2**BLK_LEN) * 8 / BEAT_W;
  localparam int unsigned LANES  = SRAM_W / BEAT_W;
  localparam int unsigned MACROS = WAYS * BANKS;
  localparam int unsigned BankW  = $clog2(BANKS);
  localparam int unsigned LaneW  = $clog2(LANES);
  localparam int unsigned CntW   = $clog2(BEATS);

  state_e             state_q;
  logic [IDX_LEN-1:0] rf_index_q;
  logic [WAYS-1:0]    rf_way_q;
  logic [WAYS-1:0]    rd_way_q;
  logic [BankW-1:0]   rd_bank_q;
  logic [1:0]         rd_word_q;
  logic               rf_done_q;

  logic               rf_go;
  logic               rd_acc;
  logic               beat_acc;
  logic [BankW-1:0]   rd_bank;
  logic [BankW-1:0]   ctr_bank;
  logic [LaneW-1:0]   ctr_lane;
  logic               ctr_last;
  logic               fwd_ok;
  logic               fwd_valid;
  logic [WORD_W-1:0]  fwd_data;

  // Byte-within-word bits never matter for a 32-bit instruction fetch.
  logic unused_offset;
  assign unused_offset = ^rd_offset_i[1:0];

  assign rf_go           = (state_q == StIdle) && rf_start_i;
  assign beat_acc        = (state_q == StRefill) && rf_beat_valid_i;
  assign rd_acc          = rd_valid_i && rd_ready_o && (state_q != StRefill);
  assign rd_bank         = BankW'(bank_of(32'(rd_offset_i)));
  assign rf_beat_ready_o = (state_q == StRefill);
  assign rf_done_o       = rf_done_q;

  icache_refill_ctr #(
    .BEATS (BEATS),
    .LANES (LANES)
  ) u_refill_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rf_go),
    .inc_i  (beat_acc),
    .bank_o (ctr_bank),
    .lane_o (ctr_lane),
    .last_o (ctr_last)
  );

  // Read acceptance: refill start wins in IDLE; RD_WAIT pipelines the next read.
  always_comb begin
    rd_ready_o = 1'b0;
    case (state_q)
      StIdle:   rd_ready_o = !rf_start_i;
      StRdWait: rd_ready_o = 1'b1;
      StRefill: rd_ready_o = fwd_ok;
      default:  rd_ready_o = 1'b0;
    endcase
  end

  // Main FSM plus the request-side latches it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rf_index_q <= '0;
      rf_way_q   <= '0;
      rd_way_q   <= '0;
      rd_bank_q  <= '0;
      rd_word_q  <= '0;
      rf_done_q  <= 1'b0;
    end else begin
      rf_done_q <= 1'b0;
      if (rd_acc) begin
        rd_way_q  <= rd_way_i;
        rd_bank_q <= rd_bank;
        rd_word_q <= rd_offset_i[3:2];
      end
      case (state_q)
        StIdle: begin
          if (rf_start_i) begin
            rf_index_q <= rf_index_i;
            rf_way_q   <= rf_way_i;
            state_q    <= StRefill;
          end else if (rd_valid_i) begin
            state_q <= StRdWait;
          end
        end
        StRdWait: state_q <= rd_valid_i ? StRdWait : StIdle;
        StRefill: begin
          if (beat_acc && ctr_last) begin
            state_q   <= StIdle;
            rf_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-macro strobes: a refill beat writes one lane of one bank in the victim
  // way; a read enables only the addressed bank of the hit way.
  always_comb begin
    sram_cen_o   = '1;
    sram_wen_o   = '1;
    sram_wmask_o = '1;
    sram_wdata_o = {(MACROS * LANES){rf_beat_data_i}};
    sram_addr_o  = '0;
    for (int unsigned m = 0; m < MACROS; m++) begin
      sram_addr_o[m*IDX_LEN +: IDX_LEN] = (state_q == StRefill) ? rf_index_q : rd_index_i;
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (beat_acc && rf_way_q[w]) begin
        sram_cen_o[w*BANKS + 32'(ctr_bank)] = 1'b0;
        sram_wen_o[w*BANKS + 32'(ctr_bank)] = 1'b0;
        sram_wmask_o[(w*BANKS + 32'(ctr_bank))*SRAM_W + 32'(ctr_lane)*BEAT_W +: BEAT_W] = '0;
      end else if (rd_acc && rd_way_i[w]) begin
        sram_cen_o[w*BANKS + 32'(rd_bank)] = 1'b0;
      end
    end
  end

  // Response mux: a miss (no way latched) yields zero.
  always_comb begin
    rsp_data_o = '0;
    if (state_q == StRdWait) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (rd_way_q[w]) begin
          rsp_data_o = rsp_data_o |
            sram_rdata_i[(w*BANKS + 32'(rd_bank_q))*SRAM_W + 32'(rd_word_q)*WORD_W +: WORD_W];
        end
      end
    end
    if (fwd_valid) begin
      rsp_data_o = fwd_data;
    end
  end

  assign rsp_valid_o = (state_q == StRdWait) || fwd_valid;

`ifdef ICACHE_DATA_FWD_EN
  localparam int unsigned WordsPerBeat = BEAT_W / WORD_W;

  logic [BEATS-1:0][BEAT_W-1:0] line_q;
  logic [CntW-1:0]              cur_beat;
  logic [CntW-1:0]              fwd_beat;
  logic [BLK_LEN-3:0]           fwd_word;
  logic [BEAT_W-1:0]            fwd_src;
  logic                         fwd_acc;
  logic                         fwd_valid_q;
  logic [WORD_W-1:0]            fwd_data_q;

  assign cur_beat = {ctr_bank, ctr_lane};
  assign fwd_word = rd_offset_i[BLK_LEN-1:2];
  assign fwd_beat = CntW'(32'(fwd_word) / WordsPerBeat);
  // Word is available if its beat is already stored or is on the bus right now.
  assign fwd_ok   = (state_q == StRefill) && (rd_index_i == rf_index_q) &&
                    (rd_way_i == rf_way_q) &&
                    ((fwd_beat < cur_beat) || ((fwd_beat == cur_beat) && rf_beat_valid_i));
  assign fwd_acc  = rd_valid_i && fwd_ok;
  assign fwd_src  = (fwd_beat == cur_beat) ? rf_beat_data_i : line_q[fwd_beat];

  // Shadow copy of the line under refill.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      line_q[cur_beat] <= rf_beat_data_i;
    end
  end

  // Forwarded response registered to match the SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_acc;
      if (fwd_acc) begin
        fwd_data_q <= fwd_src[(32'(fwd_word) % WordsPerBeat)*WORD_W +: WORD_W];
      end
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_data  = fwd_data_q;
`else
  assign fwd_ok    = 1'b0;
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_icache_data_array.sv
// Directed bench for icache_data_array with a behavioural SRAM macro model.
module tb_icache_data_array;

  localparam int IDX   = 7;
  localparam int BLK   = 6;
  localparam int WAYS  = 2;
  localparam int BEAT  = 32;
  localparam int BANKS = 4;
  localparam int MAC   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rd_valid = 1'b0;
  logic                 rd_ready;
  logic [IDX-1:0]       rd_index = '0;
  logic [BLK-1:0]       rd_offset = '0;
  logic [WAYS-1:0]      rd_way = '0;
  logic                 rsp_valid;
  logic [31:0]          rsp_data;
  logic                 rf_start = 1'b0;
  logic [IDX-1:0]       rf_index = '0;
  logic [WAYS-1:0]      rf_way = '0;
  logic                 rf_beat_valid = 1'b0;
  logic [BEAT-1:0]      rf_beat_data = '0;
  logic                 rf_beat_ready;
  logic                 rf_done;
  logic [MAC*IDX-1:0]   sram_addr;
  logic [MAC-1:0]       sram_cen;
  logic [MAC-1:0]       sram_wen;
  logic [MAC*128-1:0]   sram_wmask;
  logic [MAC*128-1:0]   sram_wdata;
  logic [MAC*128-1:0]   sram_rdata = '0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [127:0] mem [MAC][128];

  always #5 clk = ~clk;

  icache_data_array #(
    .IDX_LEN (IDX),
    .BLK_LEN (BLK),
    .WAYS    (WAYS),
    .BEAT_W  (BEAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_valid_i      (rd_valid),
    .rd_ready_o      (rd_ready),
    .rd_index_i      (rd_index),
    .rd_offset_i     (rd_offset),
    .rd_way_i        (rd_way),
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .rf_start_i      (rf_start),
    .rf_index_i      (rf_index),
    .rf_way_i        (rf_way),
    .rf_beat_valid_i (rf_beat_valid),
    .rf_beat_data_i  (rf_beat_data),
    .rf_beat_ready_o (rf_beat_ready),
    .rf_done_o       (rf_done),
    .sram_addr_o     (sram_addr),
    .sram_cen_o      (sram_cen),
    .sram_wen_o      (sram_wen),
    .sram_wmask_o    (sram_wmask),
    .sram_wdata_o    (sram_wdata),
    .sram_rdata_i    (sram_rdata)
  );

  // SRAM macros: active-low strobes, bit mask, one-cycle read latency.
  always @(posedge clk) begin
    for (int m = 0; m < MAC; m++) begin
      if (!sram_cen[m]) begin
        if (!sram_wen[m]) begin
          mem[m][sram_addr[m*IDX +: IDX]] <=
            (mem[m][sram_addr[m*IDX +: IDX]] & sram_wmask[m*128 +: 128]) |
            (sram_wdata[m*128 +: 128] & ~sram_wmask[m*128 +: 128]);
        end else begin
          sram_rdata[m*128 +: 128] <= mem[m][sram_addr[m*IDX +: IDX]];
        end
      end
    end
  end

  always @(negedge clk) if (rf_done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAC-1:0] one_low(input int m);
    logic [MAC-1:0] v;
    v = '1;
    v[m] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (sram_cen !== '1) begin errors++; $display("FAIL reset_cen got %h want ff", sram_cen); end
    checks++; if (sram_wen !== '1) begin errors++; $display("FAIL reset_wen got %h want ff", sram_wen); end
    checks++; if (sram_wmask !== '1) begin errors++; $display("FAIL reset_wmask not all ones"); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
    checks++; if (rf_done !== 1'b0) begin errors++; $display("FAIL reset_rf_done got %b want 0", rf_done); end
  endtask

  task automatic test_refill();
    int d0;
    int m;
    logic [MAC*128-1:0] em;
    logic [31:0] data;
    d0 = done_cnt;
    rf_start = 1'b1; rf_index = 7'h05; rf_way = 2'b10;
    step();
    rf_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        rf_beat_valid = 1'b0;
        #1;
        checks++; if (sram_cen !== '1) begin errors++; $display("FAIL refill_gap_cen got %h want ff", sram_cen); end
        checks++; if (rf_beat_ready !== 1'b1) begin errors++; $display("FAIL refill_gap_ready got %b want 1", rf_beat_ready); end
        step();
      end
      data = 32'h1000 + 32'(i);
      rf_beat_valid = 1'b1; rf_beat_data = data;
      #1;
      m = 4 + i / 4;
      em = '1;
      em[m*128 + (i % 4)*32 +: 32] = '0;
      checks++; if (sram_cen !== one_low(m)) begin errors++; $display("FAIL refill_cen beat %0d got %h want %h", i, sram_cen, one_low(m)); end
      checks++; if (sram_wen !== one_low(m)) begin errors++; $display("FAIL refill_wen beat %0d got %h want %h", i, sram_wen, one_low(m)); end
      checks++; if (sram_wmask !== em) begin errors++; $display("FAIL refill_wmask beat %0d wrong lane", i); end
      checks++; if (sram_wdata[m*128 +: 128] !== {4{data}}) begin errors++; $display("FAIL refill_wdata beat %0d got %h want %h", i, sram_wdata[m*128 +: 128], {4{data}}); end
      checks++; if (sram_addr[m*IDX +: IDX] !== 7'h05) begin errors++; $display("FAIL refill_addr beat %0d got %h want 05", i, sram_addr[m*IDX +: IDX]); end
      checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL refill_rd_ready beat %0d got %b want 0", i, rd_ready); end
      checks++; if (rf_done !== 1'b0) begin errors++; $display("FAIL refill_early_done beat %0d got %b want 0", i, rf_done); end
      step();
    end
    rf_beat_valid = 1'b0;
    #1;
    checks++; if (rf_done !== 1'b1) begin errors++; $display("FAIL refill_done got %b want 1", rf_done); end
    checks++; if (rf_beat_ready !== 1'b0) begin errors++; $display("FAIL refill_back_idle got %b want 0", rf_beat_ready); end
    step();
    checks++; if (rf_done !== 1'b0) begin errors++; $display("FAIL refill_done_pulse got %b want 0", rf_done); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL refill_done_count got %0d want %0d", done_cnt - d0, 1); end
    // Readback offset 0x24: bank 2, word 1 -> beat 9.
    rd_valid = 1'b1; rd_index = 7'h05; rd_offset = 6'h24; rd_way = 2'b10;
    #1;
    checks++; if (sram_cen !== one_low(6)) begin errors++; $display("FAIL readback_cen got %h want %h", sram_cen, one_low(6)); end
    checks++; if (sram_wen !== '1) begin errors++; $display("FAIL readback_wen got %h want ff", sram_wen); end
    step();
    rd_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL readback_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h00001009) begin errors++; $display("FAIL readback_data got %h want 00001009", rsp_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  offs [3];
    logic [31:0] exp  [3];
    offs = '{6'h00, 6'h14, 6'h3C};
    exp  = '{32'h00001000, 32'h00001005, 32'h0000100F};
    rd_index = 7'h05; rd_way = 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        rd_valid = 1'b1; rd_offset = offs[k];
      end else begin
        rd_valid = 1'b0;
      end
      #1;
      if (k < 3) begin
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready %0d got %b want 1", k, rd_ready); end
        checks++; if (sram_cen !== one_low(4 + int'(offs[k] >> 4))) begin errors++; $display("FAIL b2b_cen %0d got %h want %h", k, sram_cen, one_low(4 + int'(offs[k] >> 4))); end
      end
      if (k > 0) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid %0d got %b want 1", k - 1, rsp_valid); end
        checks++; if (rsp_data !== exp[k-1]) begin errors++; $display("FAIL b2b_data %0d got %h want %h", k - 1, rsp_data, exp[k-1]); end
      end
      step();
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_miss();
    rd_valid = 1'b1; rd_index = 7'h05; rd_offset = 6'h10; rd_way = 2'b00;
    #1;
    checks++; if (sram_cen !== '1) begin errors++; $display("FAIL miss_cen got %h want ff", sram_cen); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL miss_ready got %b want 1", rd_ready); end
    step();
    rd_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL miss_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL miss_data got %h want 0", rsp_data); end
    step();
  endtask

  task automatic test_start_priority();
    rf_start = 1'b1; rf_index = 7'h03; rf_way = 2'b01;
    rd_valid = 1'b1; rd_index = 7'h03; rd_offset = 6'h00; rd_way = 2'b01;
    #1;
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b want 0", rd_ready); end
    checks++; if (sram_cen !== '1) begin errors++; $display("FAIL prio_cen got %h want ff", sram_cen); end
    step();
    rf_start = 1'b0; rd_valid = 1'b0;
    #1;
    checks++; if (rf_beat_ready !== 1'b1) begin errors++; $display("FAIL prio_refill got %b want 1", rf_beat_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL prio_no_rsp got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_refill();
    int d0;
    logic [MAC*128-1:0] em;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      rf_beat_valid = 1'b1; rf_beat_data = 32'h2000 + 32'(i);
      step();
    end
    rf_beat_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (rf_beat_ready !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", rf_beat_ready); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", rd_ready); end
    checks++; if (rf_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", rf_done); end
    checks++; if (sram_cen !== '1) begin errors++; $display("FAIL rstmid_cen got %h want ff", sram_cen); end
    rf_start = 1'b1; rf_index = 7'h03; rf_way = 2'b01;
    step();
    rf_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        rf_start = 1'b1; rf_index = 7'h09; rf_way = 2'b10;
      end
      rf_beat_valid = 1'b1; rf_beat_data = 32'h3000 + 32'(i);
      #1;
      if (i == 0) begin
        em = '1;
        em[31:0] = '0;
        checks++; if (sram_cen !== one_low(0)) begin errors++; $display("FAIL restart_cen got %h want %h", sram_cen, one_low(0)); end
        checks++; if (sram_wmask !== em) begin errors++; $display("FAIL restart_lane wmask not lane 0 of macro 0"); end
      end
      if (i == 2) begin
        checks++; if (sram_cen !== one_low(0)) begin errors++; $display("FAIL ignore_start_cen got %h want %h", sram_cen, one_low(0)); end
        checks++; if (sram_addr[IDX-1:0] !== 7'h03) begin errors++; $display("FAIL ignore_start_addr got %h want 03", sram_addr[IDX-1:0]); end
      end
      step();
      rf_start = 1'b0;
    end
    rf_beat_valid = 1'b0;
    #1;
    checks++; if (rf_done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", rf_done); end
    step();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rstmid_done_count got %0d want 1", done_cnt - d0); end
    rd_valid = 1'b1; rd_index = 7'h03; rd_offset = 6'h20; rd_way = 2'b01;
    step();
    rd_valid = 1'b0;
    #1;
    checks++; if (rsp_data !== 32'h00003008) begin errors++; $display("FAIL restart_readback got %h want 00003008", rsp_data); end
    step();
  endtask

`ifdef ICACHE_DATA_FWD_EN
  task automatic test_fwd();
    logic pend;
    rf_start = 1'b1; rf_index = 7'h11; rf_way = 2'b10;
    step();
    rf_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rf_beat_valid = 1'b1; rf_beat_data = 32'h4000 + 32'(i);
      step();
    end
    rf_beat_valid = 1'b0;
    rd_valid = 1'b1; rd_index = 7'h11; rd_offset = 6'h08; rd_way = 2'b10;
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got %b want 1", rd_ready); end
    checks++; if (sram_cen !== '1) begin errors++; $display("FAIL fwd_cen got %h want ff", sram_cen); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h00004002) begin errors++; $display("FAIL fwd_data got %h want 00004002", rsp_data); end
    pend = 1'b1;
    for (int i = 4; i < 16; i++) begin
      rf_beat_valid = 1'b1; rf_beat_data = 32'h4000 + 32'(i);
      rd_valid = pend; rd_offset = 6'h30;
      #1;
      if (i < 12) begin
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL fwd_stall beat %0d got %b want 0", i, rd_ready); end
      end else if (i == 12) begin
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL fwd_release got %b want 1", rd_ready); end
        checks++; if (sram_cen !== one_low(7)) begin errors++; $display("FAIL fwd_release_cen got %h want %h", sram_cen, one_low(7)); end
      end
      step();
      if (i == 12) begin
        pend = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fwd12_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 32'h0000400C) begin errors++; $display("FAIL fwd12_data got %h want 0000400c", rsp_data); end
      end
    end
    rf_beat_valid = 1'b0; rd_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_refill();
    test_back_to_back();
    test_miss();
    test_start_priority();
    test_reset_mid_refill();
`ifdef ICACHE_DATA_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
